// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the 4-bit registered ALU.
//   a, b : 4-bit unsigned operands (b doubles as the shift amount)
//   s    : 2-bit operation select
//   f    : registered 4-bit result
//   y    : registered status word; bit 0 is carry / no-borrow, bits 3:1 are 0
// master drives operands and select and samples the results;
// slave (the ALU) does the reverse.
interface alu_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [1:0] s;
  logic [3:0] f;
  logic [3:0] y;

  modport master (output a, b, s, input f, y);
  modport slave  (input a, b, s, output f, y);
endinterface

// File: rtl/alu.sv
// alu: 4-bit registered arithmetic/logic unit.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; clears f and y
//   bus   : alu_if slave port (a, b, s in; f, y out)
// Operation select s: 00 ADD, 01 SUB, 10 SHL (a << b), 11 AND.
// Result and status are computed combinationally and captured every
// rising edge, so the output reflects the operands from the previous edge.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_SHL = 2'b10,
    OP_AND = 2'b11
  } op_e;

  op_e        op;
  logic [4:0] sum;
  logic [3:0] f_next;
  logic [3:0] y_next;

  assign op = op_e'(bus.s);

  always_comb begin
    sum    = '0;
    f_next = '0;
    y_next = '0;
    unique case (op)
      OP_ADD: begin
        sum    = {1'b0, bus.a} + {1'b0, bus.b};
        f_next = sum[3:0];
        y_next = {3'b000, sum[4]};
      end
      OP_SUB: begin
        // Two's-complement subtract; carry out set means no borrow.
        sum    = {1'b0, bus.a} + {1'b0, ~bus.b} + 5'd1;
        f_next = sum[3:0];
        y_next = {3'b000, sum[4]};
      end
      OP_SHL: begin
        // Any shift of 4 or more clears every bit of a 4-bit word.
        if (bus.b[3:2] != 2'b00)
          f_next = '0;
        else
          f_next = bus.a << bus.b[1:0];
      end
      OP_AND: begin
        f_next = bus.a & bus.b;
      end
      default: begin
        f_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.f <= '0;
      bus.y <= '0;
    end else begin
      bus.f <= f_next;
      bus.y <= y_next;
    end
  end

endmodule

// File: tb/tb_alu.sv
module tb_alu;
  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  alu_if bus ();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the operation definitions.
  function automatic void model(input int ia, input int ib, input int is,
                                output logic [3:0] ef, output logic [3:0] ey);
    int r;
    int c;
    r = 0;
    c = 0;
    case (is)
      0: begin r = (ia + ib) % 16; c = (ia + ib >= 16) ? 1 : 0; end
      1: begin r = (ia - ib + 16) % 16; c = (ia >= ib) ? 1 : 0; end
      2: r = (ib >= 4) ? 0 : (ia * (1 << ib)) % 16;
      default: r = ia & ib;
    endcase
    ef = 4'(r);
    ey = 4'(c);
  endfunction

  task automatic check(input string tag, input logic [3:0] ef, input logic [3:0] ey);
    vectors++;
    assert (bus.f === ef && bus.y === ey)
    else begin
      miscompares++;
      $error("FAIL %s: got f=%b y=%b, expected f=%b y=%b", tag, bus.f, bus.y, ef, ey);
    end
  endtask

  task automatic drive(input logic [3:0] ta, input logic [3:0] tb, input logic [1:0] ts);
    bus.a = ta;
    bus.b = tb;
    bus.s = ts;
  endtask

  // Drive operands, let one rising edge capture them, then check #1 later.
  task automatic step(input string tag, input logic [3:0] ta, input logic [3:0] tb,
                      input logic [1:0] ts, input logic [3:0] ef, input logic [3:0] ey);
    drive(ta, tb, ts);
    @(posedge clk);
    #1;
    check(tag, ef, ey);
  endtask

  initial begin
    logic [3:0] ef;
    logic [3:0] ey;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [1:0] rs;
    vectors     = 0;
    miscompares = 0;

    // Reset held across several edges with live operands.
    rst_n = 1'b0;
    drive(4'b0101, 4'b0011, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operations.
    step("add_5_3",   4'b0101, 4'b0011, 2'b00, 4'b1000, 4'b0000);
    step("add_15_1",  4'b1111, 4'b0001, 2'b00, 4'b0000, 4'b0001);
    step("sub_5_3",   4'b0101, 4'b0011, 2'b01, 4'b0010, 4'b0001);
    step("sub_3_5",   4'b0011, 4'b0101, 2'b01, 4'b1110, 4'b0000);
    step("sub_7_7",   4'b0111, 4'b0111, 2'b01, 4'b0000, 4'b0001);
    step("sub_0_1",   4'b0000, 4'b0001, 2'b01, 4'b1111, 4'b0000);
    step("shl_5_3",   4'b0101, 4'b0011, 2'b10, 4'b1000, 4'b0000);
    step("shl_5_1",   4'b0101, 4'b0001, 2'b10, 4'b1010, 4'b0000);
    step("shl_5_0",   4'b0101, 4'b0000, 2'b10, 4'b0101, 4'b0000);
    step("shl_15_4",  4'b1111, 4'b0100, 2'b10, 4'b0000, 4'b0000);
    step("shl_15_9",  4'b1111, 4'b1001, 2'b10, 4'b0000, 4'b0000);
    step("and_5_3",   4'b0101, 4'b0011, 2'b11, 4'b0001, 4'b0000);
    step("and_15_10", 4'b1111, 4'b1010, 2'b11, 4'b1010, 4'b0000);

    // Asynchronous reset between edges clears outputs with no clock edge.
    step("pre_async", 4'b1111, 4'b1111, 2'b11, 4'b1111, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 4'b0000, 4'b0000);
    drive(4'b1001, 4'b0011, 2'b00);
    @(posedge clk);
    #1;
    check("async_hold", 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    step("post_reset", 4'b1001, 4'b0011, 2'b00, 4'b1100, 4'b0000);

    // Back-to-back: every combination, opcode changing each cycle.
    for (int i = 0; i < 1024; i++) begin
      ra = 4'(i >> 2);
      rb = 4'(i >> 6);
      rs = 2'(i);
      model(int'(ra), int'(rb), int'(rs), ef, ey);
      step("exhaustive", ra, rb, rs, ef, ey);
    end

    // Randomized back-to-back vectors.
    for (int i = 0; i < 400; i++) begin
      ra = 4'($urandom_range(15, 0));
      rb = 4'($urandom_range(15, 0));
      rs = 2'($urandom_range(3, 0));
      model(int'(ra), int'(rb), int'(rs), ef, ey);
      step("random", ra, rb, rs, ef, ey);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- 4-bit registered arithmetic/logic unit.
- Performs one of add, subtract, left shift or bitwise AND on two 4-bit operands, selected by a 2-bit opcode.
- Drives a 4-bit result and a 4-bit status word, both registered on the clock.
- Used as a small datapath leaf; upstream logic presents operands and opcode, downstream logic samples the result one cycle later.

Parameters:
- None. The width is fixed at 4 bits and is not parameterised.

Ports:
- clk    input   1  rising-edge clock.
- rst_n  input   1  asynchronous, active-low reset.
- a      input   4  operand A, unsigned.
- b      input   4  operand B, unsigned; also the shift amount.
- s      input   2  operation select.
- f      output  4  registered result.
- y      output  4  registered status word; only bit 0 is used, bits 3:1 are always 0.

Behaviour:
- Reset:
  - rst_n low asynchronously forces f=4'b0000 and y=4'b0000, independent of clk.
  - Outputs stay at 0 while rst_n is low.
  - Release is sampled at the next rising clk edge.
  - Reset asserted mid-operation discards the pending result.
- Timing:
  - Combinational compute from a, b, s.
  - Captured into f/y on every rising clk edge while rst_n is high.
  - Latency is 1 cycle; a new operation is accepted every cycle.
  - No handshake and no enable.
- s=2'b00, ADD:
  - 5-bit sum = a + b.
  - f = sum[3:0]; y = {3'b000, sum[4]} (carry out).
- s=2'b01, SUB:
  - Computed as a + ~b + 1 in 5 bits.
  - f = low 4 bits; y = {3'b000, carry}.
  - carry=1 means no borrow (a >= b); carry=0 means borrow (a < b). f wraps modulo 16.
- s=2'b10, SHL:
  - f = a logically shifted left by b, zero fill, truncated to 4 bits.
  - Any b >= 4 gives f = 0.
  - y = 4'b0000; shifted-out bits are discarded.
- s=2'b11, AND:
  - f = a & b; y = 4'b0000.
- Boundaries:
  - ADD 15+1 gives f=0000, y=0001.
  - SUB 0-1 gives f=1111, y=0000.
  - SUB a==b gives f=0000, y=0001.
- Every s encoding is defined; there is no illegal opcode.
- X/Z on inputs is not handled specially.

Test Plan:
- Reset: hold rst_n=0 with a=0101, b=0011, s=00 and toggle clk -> f=0000, y=0000. Asserting rst_n between clock edges clears the outputs immediately.
- ADD: a=0101, b=0011, s=00, one clk -> f=1000, y=0000. Then a=1111, b=0001 -> f=0000, y=0001.
- SUB: a=0101, b=0011, s=01 -> f=0010, y=0001. Then a=0011, b=0101 -> f=1110, y=0000. Then a=0111, b=0111 -> f=0000, y=0001.
- SHL: a=0101, b=0011, s=10 -> f=1000, y=0000. a=0101, b=0001 -> f=1010. a=0101, b=0000 -> f=0101. a=1111, b=0100 -> f=0000.
- AND: a=0101, b=0011, s=11 -> f=0001, y=0000. a=1111, b=1010 -> f=1010.
- Pipelining: change a/b/s every cycle through all four opcodes. Each f/y must match the inputs from the previous rising edge, with no bubbles. Compare against a reference model across all 1024 combinations of a, b and s.
